uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Sequencer and buffer between uart_rx and the APB register file. Captures each received
//   frame on the rx_done handshake and returns the host_read_data acknowledge to uart_rx.
//   Stores {parity_error, rx_data} in a receive FIFO and drives RTS flow control from FIFO level.
//   Keeps sticky overrun/parity error flags and raises an interrupt.
// PARAMETERS
//   DEPTH          8   FIFO entries; power of two, >= 4
//   RTS_THRESHOLD  6   level at/above which rts_n_out deasserts; 2 <= value <= DEPTH
// PORTS
//   clk             in   1            system clock
//   reset_n         in   1            asynchronous active-low reset
//   rx_enable       in   1            APB cfg: receiver enabled
//   rx_done         in   1            from uart_rx: frame complete (level; rising edge is the event)
//   rx_data         in   8            from uart_rx: received data
//   parity_error    in   1            from uart_rx: parity result for the frame
//   host_read_data  out  1            to uart_rx: one-cycle acknowledge, clears its rx_done
//   rd_en           in   1            APB read strobe of the RX data register, one cycle
//   rd_data         out  8            FIFO head data; 0 when empty
//   flush           in   1            synchronous FIFO clear
//   fifo_empty      out  1            FIFO empty
//   fifo_full       out  1            FIFO full
//   fifo_level      out  $clog2(DEPTH)+1  occupied entries
//   overrun_err     out  1            sticky: frame dropped because FIFO was full
//   parity_err      out  1            sticky: a frame with parity_error=1 was stored
//   err_clr         in   1            clears both sticky flags
//   irq_en          in   1            interrupt enable
//   irq             out  1            registered interrupt
//   rts_n_out       out  1            to peripheral: 0 = ready to receive
// BEHAVIOUR
//   Reset: state IDLE, pointers and level 0, all flags 0, host_read_data 0, irq 0, rts_n_out 0.
//   Edge detect: rx_rise = rx_done & ~rx_done_q; rx_done_q resets to 0.
//   FSM (3 states):
//   - IDLE -> CAPTURE when rx_rise & rx_enable. rx_rise with rx_enable=0 is ignored; no ack is sent.
//   - CAPTURE, one cycle: if !full or rd_en in the same cycle, write {parity_error, rx_data}.
//     Otherwise set overrun_err and drop the frame. Next state is ACK.
//   - ACK, one cycle: host_read_data=1, then IDLE. host_read_data is 0 in all other states.
//   Latency: rx_rise in cycle N -> write at the end of N+1 -> fifo_level updated in N+2.
//     host_read_data is high in N+2.
//   FIFO: pointers are $clog2(DEPTH) bits wide and wrap naturally.
//     Level is a separate counter from 0 to DEPTH.
//   rd_en when empty: no effect. rd_data is combinational from the head entry.
//   Write and read in the same cycle: both take effect and the level is unchanged.
//   flush: pointers/level go to 0 next cycle and a same-cycle write is discarded. FSM unaffected.
//   Sticky flags: parity_err is set on a write whose stored parity bit is 1.
//     err_clr clears both flags. Set wins over err_clr in the same cycle.
//   rts_n_out (registered, hysteresis):
//   - goes to 1 when level >= RTS_THRESHOLD or rx_enable=0;
//   - goes to 0 when level <= RTS_THRESHOLD-2 and rx_enable=1;
//   - otherwise holds its value.
//   irq <= irq_en & (!fifo_empty | overrun_err | parity_err), registered.
//   rx_enable dropped mid-sequence: a CAPTURE/ACK in progress completes normally.
//   reset_n asserted mid-frame: everything returns to reset values at once. Stored data is lost.
// STRUCTURE
//   uart_pkg: rx_ctrl_state_e {IDLE, CAPTURE, ACK} and the rx_entry_t struct {logic perr; logic [7:0] data}.
//   Sub-module uart_sync_fifo #(DEPTH, type T=rx_entry_t): wr/rd/flush, empty/full/level.
//   The controller holds the FSM, edge detect, flags, RTS and irq.
// TESTING
//   1. 0x5A, parity_error=0, empty FIFO: rx_done rises at N -> host_read_data=1 at N+2;
//      level=1, rd_data=0x5A. rd_en -> level=0, rd_data=0.
//   2. Write 6 frames -> rts_n_out=1. Read 1 (level 5) -> still 1.
//      Read 1 more (level 4) -> 0.
//   3. Fill 8 frames, send 0x33 -> frame dropped, overrun_err=1, ack still sent.
//      err_clr -> 0. Repeat with rd_en coinciding with CAPTURE -> 0x33 stored, no overrun.
//   4. Frame 0xA5 with parity_error=1, irq_en=1 -> parity_err=1, irq=1.
//      err_clr asserted together with a second bad frame -> parity_err stays 1.
//   5. rx_enable=0, rx_done pulses -> no write, no host_read_data, rts_n_out=1.
//      Apply flush with a non-empty FIFO -> level 0.
//   6. Assert reset_n low during ACK -> host_read_data=0, level=0, irq=0, state IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types for the UART receive controller slice.
//   - rx_ctrl_state_e : sequencer states of uart_rx_ctrl
//   - rx_entry_t      : one receive FIFO entry {perr, data}
//   - rts_hyst()      : next value of a hysteresis flow-control output
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } rx_ctrl_state_e;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Raise wins over lower; with neither condition the output keeps its value,
    // which is what gives the RTS line its hysteresis band.
    function automatic logic rts_hyst(input logic cur, input logic go_high, input logic go_low);
        logic res;
        if (go_high) begin
            res = 1'b1;
        end else if (go_low) begin
            res = 1'b0;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO with a separate occupancy counter.
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset
//     wr_en, wr_data    push request and entry
//     rd_en             pop request (ignored when empty)
//     flush             synchronous clear; discards a same-cycle push/pop
//     rd_data           head entry, all-zero when empty
//     empty, full       occupancy flags
//     level             occupied entries, 0..DEPTH
//   A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = rx_entry_t
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  T                         wr_data,
    input  logic                     rd_en,
    input  logic                     flush,
    output T                         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    T              mem_q [DEPTH];
    logic          rd_ok_s;
    logic          wr_ok_s;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    assign level = level_q;

    // Accepted push/pop and next pointer/level values.
    always_comb begin
        rd_ok_s  = rd_en & ~empty;
        wr_ok_s  = wr_en & (~full | rd_ok_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Head entry; reads as zero when nothing is stored.
    always_comb begin
        if (empty) begin
            rd_data = '0;
        end else begin
            rd_data = mem_q[rd_ptr_q];
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; a flushed push never lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Sequencer and receive buffer between uart_rx and the APB register file.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     rx_enable                    receiver enabled
//     rx_done/rx_data/parity_error frame handshake from uart_rx
//     host_read_data               one-cycle acknowledge back to uart_rx
//     rd_en, rd_data               RX data register read strobe / FIFO head
//     flush                        synchronous FIFO clear
//     fifo_empty/full/level        FIFO status
//     overrun_err, parity_err      sticky error flags, cleared by err_clr
//     irq_en, irq                  interrupt enable / registered interrupt
//     rts_n_out                    flow control, 0 = ready to receive
//   Sequence: rx_done rising edge (while enabled) -> CAPTURE (store or drop)
//   -> ACK (host_read_data high) -> IDLE.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int RTS_THRESHOLD = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rx_enable,
    input  logic                    rx_done,
    input  logic [7:0]              rx_data,
    input  logic                    parity_error,
    output logic                    host_read_data,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    input  logic                    flush,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overrun_err,
    output logic                    parity_err,
    input  logic                    err_clr,
    input  logic                    irq_en,
    output logic                    irq,
    input  logic                    rts_n_out_unused_tie = 1'b0,
    output logic                    rts_n_out
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] RTS_HI = LW'(RTS_THRESHOLD);
    localparam logic [LW-1:0] RTS_LO = LW'(RTS_THRESHOLD - 2);

    rx_ctrl_state_e state_q, state_d;
    logic           rx_done_q, rx_done_d;
    logic           overrun_q, overrun_d;
    logic           parity_q, parity_d;
    logic           irq_q, irq_d;
    logic           rts_n_q, rts_n_d;

    logic           rx_rise_s;
    logic           capture_s;
    logic           fifo_wr_s;
    logic           drop_s;
    logic           perr_store_s;
    rx_entry_t      wr_entry_s;
    rx_entry_t      head_s;
    logic           unused_head_perr_s;
    logic           unused_tie_s;

    assign rx_rise_s  = rx_done & ~rx_done_q;
    assign capture_s  = (state_q == CAPTURE);
    // A full FIFO still accepts the frame when the host pops in the same cycle.
    assign fifo_wr_s  = capture_s & (~fifo_full | rd_en);
    assign drop_s     = capture_s & fifo_full & ~rd_en;
    // A flushed write is discarded, so it cannot mark a parity error either.
    assign perr_store_s = fifo_wr_s & ~flush & parity_error;
    assign wr_entry_s = '{perr: parity_error, data: rx_data};

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (rx_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr_s),
        .wr_data (wr_entry_s),
        .rd_en   (rd_en),
        .flush   (flush),
        .rd_data (head_s),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    assign rd_data            = head_s.data;
    assign unused_head_perr_s = head_s.perr;
    assign unused_tie_s       = rts_n_out_unused_tie;

    assign host_read_data = (state_q == ACK);
    assign overrun_err    = overrun_q;
    assign parity_err     = parity_q;
    assign irq            = irq_q;
    assign rts_n_out      = rts_n_q;

    // Next-state logic for the capture/acknowledge sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_rise_s && rx_enable) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edge history, sticky flags (set beats clear), irq and RTS hysteresis.
    always_comb begin
        rx_done_d = rx_done;
        overrun_d = overrun_q;
        parity_d  = parity_q;
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (perr_store_s) begin
            parity_d = 1'b1;
        end else if (err_clr) begin
            parity_d = 1'b0;
        end else begin
            parity_d = parity_q;
        end
        irq_d   = irq_en & (~fifo_empty | overrun_q | parity_q);
        rts_n_d = rts_hyst(rts_n_q,
                           (fifo_level >= RTS_HI) | ~rx_enable,
                           (fifo_level <= RTS_LO) & rx_enable);
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rx_done_q <= 1'b0;
            overrun_q <= 1'b0;
            parity_q  <= 1'b0;
            irq_q     <= 1'b0;
            rts_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done_d;
            overrun_q <= overrun_d;
            parity_q  <= parity_d;
            irq_q     <= irq_d;
            rts_n_q   <= rts_n_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int THR   = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_enable = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       parity_error = 1'b0;
    logic       host_read_data;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       flush = 1'b0;
    logic       fifo_empty;
    logic       fifo_full;
    logic [3:0] fifo_level;
    logic       overrun_err;
    logic       parity_err;
    logic       err_clr = 1'b0;
    logic       irq_en = 1'b0;
    logic       irq;
    logic       rts_n_out;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .RTS_THRESHOLD(THR)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .rx_enable            (rx_enable),
        .rx_done              (rx_done),
        .rx_data              (rx_data),
        .parity_error         (parity_error),
        .host_read_data       (host_read_data),
        .rd_en                (rd_en),
        .rd_data              (rd_data),
        .flush                (flush),
        .fifo_empty           (fifo_empty),
        .fifo_full            (fifo_full),
        .fifo_level           (fifo_level),
        .overrun_err          (overrun_err),
        .parity_err           (parity_err),
        .err_clr              (err_clr),
        .irq_en               (irq_en),
        .irq                  (irq),
        .rts_n_out_unused_tie (1'b0),
        .rts_n_out            (rts_n_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Frames are scheduled by cycle number: a rise seen in cycle N while idle is
    // stored (or dropped) at the end of N+1 and acknowledged during N+2.
    int         cyc = 0;
    int         cap_cyc = -10;
    int         ack_cyc = -10;
    logic [8:0] mq[$];
    bit         m_prev = 0, m_ovr = 0, m_par = 0, m_irq = 0, m_rts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin : model
        bit rise, cap_now, busy, do_rd, do_wr, ovr_set, par_set, irq_n, rts_n;
        int lvl;
        if (!reset_n) begin
            mq.delete();
            m_prev = 0; m_ovr = 0; m_par = 0; m_irq = 0; m_rts = 0;
            cap_cyc = -10; ack_cyc = -10;
        end else begin
            lvl     = mq.size();
            rise    = rx_done && !m_prev;
            m_prev  = rx_done;
            cap_now = (cyc == cap_cyc);
            busy    = cap_now || (cyc == ack_cyc);
            do_rd   = rd_en && (lvl > 0);
            do_wr   = cap_now && ((lvl < DEPTH) || rd_en);
            ovr_set = cap_now && (lvl == DEPTH) && !rd_en;
            par_set = do_wr && !flush && parity_error;
            irq_n   = irq_en && ((lvl > 0) || m_ovr || m_par);
            if (lvl >= THR || !rx_enable) rts_n = 1;
            else if (lvl <= THR - 2)      rts_n = 0;
            else                          rts_n = m_rts;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_rd) void'(mq.pop_front());
                if (do_wr) mq.push_back({parity_error, rx_data});
            end
            m_ovr = ovr_set ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
            m_par = par_set ? 1'b1 : (err_clr ? 1'b0 : m_par);
            m_irq = irq_n;
            m_rts = rts_n;
            if (!busy && rise && rx_enable) begin
                cap_cyc = cyc + 1;
                ack_cyc = cyc + 2;
            end
        end
    end

    // Compare every DUT output with the model once per cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_level", 32'(fifo_level), 32'(mq.size()));
            check("m_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            check("m_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
            check("m_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0][7:0]) : 32'd0);
            check("m_ack",   32'(host_read_data), 32'(cyc == ack_cyc));
            check("m_ovr",   32'(overrun_err), 32'(m_ovr));
            check("m_par",   32'(parity_err),  32'(m_par));
            check("m_irq",   32'(irq),         32'(m_irq));
            check("m_rts",   32'(rts_n_out),   32'(m_rts));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_read();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
    endtask

    // Behaves like uart_rx: hold rx_done until acknowledged. Optional rd_en /
    // err_clr land in the CAPTURE cycle. Returns after the ACK cycle is seen.
    task automatic send_frame(input logic [7:0] d, input logic pe, input bit rd_cap,
                              input bit clr_cap, output int lat);
        bit got;
        got = 0;
        lat = -1;
        @(negedge clk);
        rx_data = d; parity_error = pe; rx_done = 1'b1;
        @(negedge clk);
        rd_en = rd_cap; err_clr = clr_cap;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            rd_en = 1'b0; err_clr = 1'b0;
            if (host_read_data) begin got = 1; lat = i; end
        end
        rx_done = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int hold;
        tick(3);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ack",   32'(host_read_data), 32'd0);
        check("rst_rts",   32'(rts_n_out), 32'd0);
        check("rst_irq",   32'(irq), 32'd0);

        // 1: single frame, latency and read back
        send_frame(8'h5A, 1'b0, 0, 0, lat);
        check("t1_latency", 32'(lat), 32'd0);
        check("t1_level",   32'(fifo_level), 32'd1);
        check("t1_rd_data", 32'(rd_data), 32'h5A);
        do_read();
        check("t1_level_after", 32'(fifo_level), 32'd0);
        check("t1_rd_data_empty", 32'(rd_data), 32'h00);

        // 2: RTS hysteresis
        for (int i = 0; i < 6; i++) send_frame(8'(8'h40 + i), 1'b0, 0, 0, lat);
        tick(1);
        check("t2_rts_at6", 32'(rts_n_out), 32'd1);
        do_read();
        check("t2_level5", 32'(fifo_level), 32'd5);
        tick(1);
        check("t2_rts_at5", 32'(rts_n_out), 32'd1);
        do_read();
        check("t2_level4", 32'(fifo_level), 32'd4);
        tick(1);
        check("t2_rts_at4", 32'(rts_n_out), 32'd0);
        for (int i = 0; i < 4; i++) do_read();
        check("t2_empty", 32'(fifo_empty), 32'd1);

        // 3: overrun, and full FIFO with a same-cycle read
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b0, 0, 0, lat);
        check("t3_full", 32'(fifo_full), 32'd1);
        send_frame(8'h33, 1'b0, 0, 0, lat);
        check("t3_overrun", 32'(overrun_err), 32'd1);
        check("t3_level8",  32'(fifo_level), 32'd8);
        check("t3_head",    32'(rd_data), 32'h10);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("t3_ovr_clr", 32'(overrun_err), 32'd0);
        send_frame(8'h33, 1'b0, 1, 0, lat);
        check("t3_no_overrun", 32'(overrun_err), 32'd0);
        check("t3_level_still8", 32'(fifo_level), 32'd8);
        check("t3_head_11", 32'(rd_data), 32'h11);
        for (int i = 0; i < 7; i++) do_read();
        check("t3_last_33", 32'(rd_data), 32'h33);
        do_read();
        check("t3_empty", 32'(fifo_empty), 32'd1);

        // 4: parity flag and irq; set beats clear
        irq_en = 1'b1;
        send_frame(8'hA5, 1'b1, 0, 0, lat);
        check("t4_par", 32'(parity_err), 32'd1);
        tick(1);
        check("t4_irq", 32'(irq), 32'd1);
        send_frame(8'h3C, 1'b1, 0, 1, lat);
        check("t4_par_stays", 32'(parity_err), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("t4_par_clr", 32'(parity_err), 32'd0);

        // 5: receiver disabled, then flush
        @(negedge clk); rx_enable = 1'b0;
        @(negedge clk); rx_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_ack", 32'(host_read_data), 32'd0);
        end
        rx_done = 1'b0;
        check("t5_level2", 32'(fifo_level), 32'd2);
        check("t5_rts", 32'(rts_n_out), 32'd1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("t5_flush", 32'(fifo_level), 32'd0);
        rx_enable = 1'b1;
        tick(2);
        check("t5_rts_back", 32'(rts_n_out), 32'd0);

        // 6: reset asserted during ACK
        send_frame(8'h21, 1'b0, 0, 0, lat);
        tick(1);
        check("t6_irq_pre", 32'(irq), 32'd1);
        @(negedge clk);
        rx_data = 8'h22; rx_done = 1'b1;
        hold = 0;
        for (int i = 0; i < 8 && !host_read_data; i++) @(negedge clk);
        check("t6_in_ack", 32'(host_read_data), 32'd1);
        #2 reset_n = 1'b0;
        rx_done = 1'b0;
        #1;
        check("t6_ack", 32'(host_read_data), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
        tick(2);
        reset_n = 1'b1;
        send_frame(8'h77, 1'b0, 0, 0, lat);
        check("t6_idle_latency", 32'(lat), 32'd0);
        check("t6_rd_data", 32'(rd_data), 32'h77);

        // Randomized traffic, model-checked every cycle
        hold = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            rd_en   = ($urandom_range(0, 7) < ((k < 400) ? 1 : 4));
            err_clr = ($urandom_range(0, 15) == 0);
            flush   = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 80) == 0) rx_enable = ~rx_enable;
            if ($urandom_range(0, 50) == 0) irq_en = ~irq_en;
            if (rx_done) begin
                hold++;
                if (host_read_data || hold > 6) rx_done = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                rx_data      = 8'($urandom);
                parity_error = ($urandom_range(0, 7) == 0);
                rx_done      = 1'b1;
                hold         = 0;
            end
        end
        @(negedge clk);
        rd_en = 1'b0; err_clr = 1'b0; flush = 1'b0; rx_done = 1'b0; rx_enable = 1'b1;
        tick(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
